issue_ctrl: RTL and testbench

//  Instruction issue controller between fetch and the schedule stage.

---
 rtl/issue_ctrl_pkg.sv | 30 +++
 rtl/issue_fifo.sv | 63 ++++++
 rtl/issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared instruction types, field bounds and FSM states for issue_ctrl
package issue_ctrl_pkg;

   // Instruction field layout: op [15:12], rd [11:8], rs [7:4]
   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 8;
   localparam int RS_HI = 7;
   localparam int RS_LO = 4;

   typedef logic [15:0] inst_t;

   localparam inst_t NOP_INST = 16'h0000;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } issue_state_e;

   // RAW hazard of a queued head against the last real instruction issued;
   // a NOP on either side never hazards
   function automatic logic raw_hazard(input inst_t head, input inst_t last);
      return (head[OP_HI:OP_LO] != 4'd0) && (last[OP_HI:OP_LO] != 4'd0) &&
             ((head[RD_HI:RD_LO] == last[RD_HI:RD_LO]) ||
              (head[RS_HI:RS_LO] == last[RD_HI:RD_LO]));
   endfunction

endpackage

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - DEPTH x WIDTH synchronous FIFO with clear, full/empty and occupancy
module issue_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // full comes from the occupancy count, so wrapped pointers never alias
   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // a push into a full FIFO is only honoured together with a pop
   assign w_push = i_push && (!o_full || i_pop);
   assign w_pop  = i_pop && !o_empty;

   // pointer and occupancy bookkeeping; clear empties the FIFO in one cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // storage write; contents need no reset because occupancy gates every read
   always_ff @(posedge i_clk) begin
      if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - fetch-to-schedule issue controller with RAW bubbles and flush; ISSUE_PERF_EN adds stall/flush counters
module issue_ctrl
   import issue_ctrl_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STALL_CYCLES = 2,
   parameter int INST_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_valid,
   input  logic [INST_W-1:0]        fetch_inst,
   output logic                     fetch_ready,
   input  logic                     do_branch,
   input  logic                     do_jump,
   output logic [INST_W-1:0]        issue_inst,
   output logic                     issue_valid,
   output logic                     stall,
   output logic [$clog2(DEPTH):0]   q_count
`ifdef ISSUE_PERF_EN
   ,
   output logic [31:0]              stall_total,
   output logic [15:0]              flush_total
`endif
);

   // the hazard cycle itself issues the first bubble, so STALL holds for
   // STALL_CYCLES-1 further cycles
   localparam int          CW       = $clog2(STALL_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'((STALL_CYCLES >= 2) ? (STALL_CYCLES - 2) : 0);

   issue_state_e        r_state;
   logic [CW-1:0]       r_cnt;
   logic [INST_W-1:0]   r_last;
   logic [INST_W-1:0]   r_issue_inst;
   logic                r_issue_valid;
   logic                r_stall;

   logic                w_flush_req;
   logic [INST_W-1:0]   w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_hazard;
   logic                w_pop_ok;
   logic                w_push;
   logic                w_pop;
   logic                w_clear;

   assign w_flush_req = do_branch | do_jump;
   assign w_hazard    = !w_empty && raw_hazard(inst_t'(w_head[15:0]), inst_t'(r_last[15:0]));
   assign w_pop_ok    = (r_state == ST_RUN) && !w_empty && !w_hazard;

   // a full FIFO still takes a push in a cycle where the head is issued
   assign fetch_ready = (!w_full || w_pop_ok) && (r_state != ST_FLUSH);
   assign w_push      = fetch_valid && fetch_ready && !w_flush_req;
   assign w_pop       = w_pop_ok && !w_flush_req;
   assign w_clear     = w_flush_req || (r_state == ST_FLUSH);

   assign issue_inst  = r_issue_inst;
   assign issue_valid = r_issue_valid;
   assign stall       = r_stall;

   issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INST_W)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_clear),
      .i_wdata (fetch_inst),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (q_count)
   );

   // issue FSM: registered issue outputs, bubble on hazard, flush over everything
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_RUN;
         r_cnt         <= '0;
         r_last        <= '0;
         r_issue_inst  <= '0;
         r_issue_valid <= 1'b0;
         r_stall       <= 1'b0;
      end else begin
         r_issue_inst  <= INST_W'(NOP_INST);
         r_issue_valid <= 1'b0;
         r_stall       <= 1'b0;
         if (w_flush_req) begin
            r_state <= ST_FLUSH;
            r_last  <= '0;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (w_hazard) begin
                     r_stall <= 1'b1;
                     if (STALL_CYCLES > 1) begin
                        r_state <= ST_STALL;
                        r_cnt   <= CNT_LOAD;
                     end else begin
                        r_last  <= '0;
                     end
                  end else if (!w_empty) begin
                     r_issue_inst  <= w_head;
                     r_issue_valid <= 1'b1;
                     r_last        <= w_head;
                  end
               end
               ST_STALL: begin
                  r_stall <= 1'b1;
                  if (r_cnt == '0) begin
                     r_state <= ST_RUN;
                     r_last  <= '0;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               ST_FLUSH: begin
                  r_last  <= '0;
                  r_state <= ST_RUN;
               end
               default: r_state <= ST_RUN;
            endcase
         end
      end
   end

`ifdef ISSUE_PERF_EN
   logic [31:0] r_stall_total;
   logic [15:0] r_flush_total;

   assign stall_total = r_stall_total;
   assign flush_total = r_flush_total;

   // saturating bubble and flush-entry counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_total <= '0;
         r_flush_total <= '0;
      end else begin
         if (r_stall && (r_stall_total != '1))
            r_stall_total <= r_stall_total + 1'b1;
         if (w_flush_req && (r_state != ST_FLUSH) && (r_flush_total != '1))
            r_flush_total <= r_flush_total + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - scoreboard bench for issue_ctrl
module tb_issue_ctrl;

   localparam int K_INST  = 0;
   localparam int K_VALID = 1;
   localparam int K_STALL = 2;
   localparam int K_QCNT  = 3;
   localparam int K_READY = 4;
   localparam int K_STOT  = 5;
   localparam int K_FTOT  = 6;
   localparam int K_LEFT  = 7;

   typedef struct {
      int          kind;
      logic [31:0] val;
   } chk_t;

   logic        clk;
   logic        rst;
   logic        fetch_valid;
   logic [15:0] fetch_inst;
   logic        fetch_ready;
   logic        do_branch;
   logic        do_jump;
   logic [15:0] issue_inst;
   logic        issue_valid;
   logic        stall;
   logic [2:0]  q_count;
`ifdef ISSUE_PERF_EN
   logic [31:0] stall_total;
   logic [15:0] flush_total;
`endif

   chk_t        chk_q[$];
   logic [15:0] exp_issue[$];
   int          n_vec;
   int          n_err;
   chk_t        cur;
   logic [15:0] exp_inst;
   logic [31:0] act;

   issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_valid (fetch_valid),
      .fetch_inst  (fetch_inst),
      .fetch_ready (fetch_ready),
      .do_branch   (do_branch),
      .do_jump     (do_jump),
      .issue_inst  (issue_inst),
      .issue_valid (issue_valid),
      .stall       (stall),
      .q_count     (q_count)
`ifdef ISSUE_PERF_EN
      ,
      .stall_total (stall_total),
      .flush_total (flush_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string kname(input int k);
      case (k)
         K_INST:  return "issue_inst";
         K_VALID: return "issue_valid";
         K_STALL: return "stall";
         K_QCNT:  return "q_count";
         K_READY: return "fetch_ready";
         K_STOT:  return "stall_total";
         K_FTOT:  return "flush_total";
         default: return "leftover_expected";
      endcase
   endfunction

   function automatic logic [31:0] sample(input int k);
      case (k)
         K_INST:  return {16'h0, issue_inst};
         K_VALID: return {31'h0, issue_valid};
         K_STALL: return {31'h0, stall};
         K_QCNT:  return {29'h0, q_count};
         K_READY: return {31'h0, fetch_ready};
`ifdef ISSUE_PERF_EN
         K_STOT:  return stall_total;
         K_FTOT:  return {16'h0, flush_total};
`endif
         default: return 32'(exp_issue.size());
      endcase
   endfunction

   // monitor: pops the in-order issue scoreboard on every valid issue, then
   // resolves the per-cycle expectations queued by the stimulus
   always @(negedge clk) begin
      if (rst && issue_valid) begin
         n_vec++;
         if (exp_issue.size() == 0) begin
            n_err++;
            $display("FAIL issue_order: got %h, expected no issue", issue_inst);
         end else begin
            exp_inst = exp_issue.pop_front();
            if (issue_inst !== exp_inst) begin
               n_err++;
               $display("FAIL issue_order: got %h, expected %h", issue_inst, exp_inst);
            end
         end
      end
      while (chk_q.size() > 0) begin
         cur = chk_q.pop_front();
         act = sample(cur.kind);
         n_vec++;
         if (act !== cur.val) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", kname(cur.kind), $time, act, cur.val);
         end
      end
   end

   task automatic expect_now(input int kind, input logic [31:0] val);
      chk_t c;
      c.kind = kind;
      c.val  = val;
      chk_q.push_back(c);
   endtask

   task automatic tick(input logic v, input logic [15:0] d, input logic j, input logic b);
      fetch_valid = v;
      fetch_inst  = d;
      do_jump     = j;
      do_branch   = b;
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      do_jump     = 1'b0;
      do_branch   = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      fetch_valid = 1'b0;
      fetch_inst = 16'h0;
      do_branch = 1'b0;
      do_jump = 1'b0;

      // reset values
      tick(0, 16'h0, 0, 0);
      expect_now(K_INST, 0); expect_now(K_VALID, 0); expect_now(K_STALL, 0);
      expect_now(K_READY, 1); expect_now(K_QCNT, 0);
      tick(0, 16'h0, 0, 0);
      rst = 1'b1;

      // 1: back-to-back independent instructions
      exp_issue.push_back(16'h1120);
      tick(1, 16'h1120, 0, 0);
      expect_now(K_QCNT, 1); expect_now(K_VALID, 0);
      exp_issue.push_back(16'h2340);
      tick(1, 16'h2340, 0, 0);
      expect_now(K_INST, 16'h1120); expect_now(K_VALID, 1); expect_now(K_STALL, 0); expect_now(K_QCNT, 1);
      tick(0, 16'h0, 0, 0);
      expect_now(K_INST, 16'h2340); expect_now(K_VALID, 1); expect_now(K_QCNT, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_VALID, 0); expect_now(K_INST, 0);

      // 2: RAW on rs -> two bubbles
      exp_issue.push_back(16'h1100);
      tick(1, 16'h1100, 0, 0);
      exp_issue.push_back(16'h2210);
      tick(1, 16'h2210, 0, 0);
      expect_now(K_INST, 16'h1100); expect_now(K_STALL, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_STALL, 1); expect_now(K_VALID, 0); expect_now(K_INST, 0); expect_now(K_QCNT, 1);
      tick(0, 16'h0, 0, 0);
      expect_now(K_STALL, 1); expect_now(K_VALID, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_INST, 16'h2210); expect_now(K_STALL, 0); expect_now(K_QCNT, 0);
      tick(0, 16'h0, 0, 0);
      tick(0, 16'h0, 0, 1);
      expect_now(K_VALID, 0); expect_now(K_READY, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_READY, 1);
`ifdef ISSUE_PERF_EN
      expect_now(K_STOT, 2); expect_now(K_FTOT, 1);
`endif

      // 3: fill to full while bubbling, then push+pop at full
      exp_issue.push_back(16'h1100); tick(1, 16'h1100, 0, 0);
      exp_issue.push_back(16'h2100); tick(1, 16'h2100, 0, 0);
      exp_issue.push_back(16'h3100); tick(1, 16'h3100, 0, 0);
      expect_now(K_STALL, 1); expect_now(K_QCNT, 2);
      exp_issue.push_back(16'h4100); tick(1, 16'h4100, 0, 0);
      exp_issue.push_back(16'h5100); tick(1, 16'h5100, 0, 0);
      exp_issue.push_back(16'h6100); tick(1, 16'h6100, 0, 0);
      expect_now(K_QCNT, 4); expect_now(K_READY, 0); expect_now(K_STALL, 1);
      tick(0, 16'h0, 0, 0);
      expect_now(K_QCNT, 4); expect_now(K_READY, 1);
      exp_issue.push_back(16'h7100); tick(1, 16'h7100, 0, 0);
      expect_now(K_QCNT, 4); expect_now(K_INST, 16'h3100); expect_now(K_VALID, 1);
      for (int i = 0; i < 16; i++) tick(0, 16'h0, 0, 0);
      expect_now(K_QCNT, 0);
      tick(0, 16'h0, 0, 1);
      tick(0, 16'h0, 0, 0);

      // 4: jump during STALL with three queued
      exp_issue.push_back(16'h1100); tick(1, 16'h1100, 0, 0);
      exp_issue.push_back(16'h2100); tick(1, 16'h2100, 0, 0);
      tick(1, 16'h3100, 0, 0);
      tick(1, 16'h4100, 0, 0);
      tick(1, 16'h5100, 0, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_STALL, 1); expect_now(K_QCNT, 3);
      tick(1, 16'h9100, 1, 0);
      expect_now(K_VALID, 0); expect_now(K_INST, 0); expect_now(K_QCNT, 0); expect_now(K_READY, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_READY, 1); expect_now(K_STALL, 0); expect_now(K_VALID, 0);
      exp_issue.push_back(16'h1100); tick(1, 16'h1100, 0, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_INST, 16'h1100); expect_now(K_VALID, 1);

      // 5: asynchronous reset mid-STALL, no stale hazard afterwards
      tick(1, 16'h2100, 0, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_STALL, 1);
      tick(0, 16'h0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      expect_now(K_INST, 0); expect_now(K_VALID, 0); expect_now(K_STALL, 0);
      expect_now(K_QCNT, 0); expect_now(K_READY, 1);
      tick(0, 16'h0, 0, 0);
      rst = 1'b1;
      exp_issue.push_back(16'h2210); tick(1, 16'h2210, 0, 0);
      expect_now(K_QCNT, 1);
      tick(0, 16'h0, 0, 0);
      expect_now(K_INST, 16'h2210); expect_now(K_VALID, 1); expect_now(K_STALL, 0);

      tick(0, 16'h0, 0, 0);
      tick(0, 16'h0, 0, 0);
      expect_now(K_LEFT, 0);
      tick(0, 16'h0, 0, 0);
      tick(0, 16'h0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
